pc_unit: RTL



---
 rtl/pc_pkg.sv | 29 ++
 rtl/pc_if.sv | 35 +++
 rtl/pc_next_calc.sv | 37 +++
 rtl/pc_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_unit shared types and constants.
// State encoding, widths and default addresses.
package pc_pkg;

  localparam int ADDR_W = 32;
  localparam int OFF_W  = 16;
  localparam int JT_W   = 26;

  localparam logic [ADDR_W-1:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] DEF_EXC_VECTOR = 32'h0000_0180;
  localparam int unsigned       DEF_IMEM_DEPTH = 1024;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2,
    HALT = 2'd3
  } pc_state_e;

  // Misaligned, or word index beyond the instruction memory.
  function automatic logic bad_addr(
    input logic [ADDR_W-1:0] a,
    input int unsigned       depth
  );
    return (a[1:0] != 2'b00) ||
           ({2'b00, a[ADDR_W-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/pc_if.sv
// Bundle between the PC stage and its surroundings.
// master drives redirects, slave is pc_unit.
interface pc_if;
  import pc_pkg::*;

  logic              stall;
  logic              branch_taken;
  logic [OFF_W-1:0]  branch_offset;
  logic              jump;
  logic [JT_W-1:0]   jump_target;
  logic              jr;
  logic [ADDR_W-1:0] jr_target;
  logic              eret;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              fetch_valid;
  logic              fault;
  logic [ADDR_W-1:0] epc;
  logic [ADDR_W-1:0] retired_count;

  modport master (
    output stall, branch_taken, branch_offset,
    output jump, jump_target, jr, jr_target, eret,
    input  pc, pc_plus4, fetch_valid,
    input  fault, epc, retired_count
  );

  modport slave (
    input  stall, branch_taken, branch_offset,
    input  jump, jump_target, jr, jr_target, eret,
    output pc, pc_plus4, fetch_valid,
    output fault, epc, retired_count
  );

endinterface

// File: rtl/pc_next_calc.sv
// Candidate next-PC selection and target check.
// Priority: jr > jump > branch > sequential.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = DEF_IMEM_DEPTH
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic              branch_taken,
  input  logic [OFF_W-1:0]  branch_offset,
  input  logic              jump,
  input  logic [JT_W-1:0]   jump_target,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] target,
  output logic              bad
);

  logic [ADDR_W-1:0] br_off;

  assign br_off = {{14{branch_offset[OFF_W-1]}},
                   branch_offset, 2'b00};

  always_comb begin
    target = pc_plus4;
    if (jr) begin
      target = jr_target;
    end else if (jump) begin
      target = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      target = pc_plus4 + br_off;
    end
  end

  assign bad = bad_addr(target, IMEM_DEPTH);

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage with boot/run/trap/halt FSM.
// Optional retire counter: define PC_RETIRE_CNT_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter int unsigned       IMEM_DEPTH = DEF_IMEM_DEPTH
) (
  input logic clk,
  input logic rst,
  pc_if.slave bus
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target;
  logic              bad;
  logic              fv;

  assign pc_plus4 = pc_q + 32'd4;
  assign fv       = (state_q == RUN) || (state_q == TRAP);

  pc_next_calc #(
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_calc (
    .pc_plus4      (pc_plus4),
    .branch_taken  (bus.branch_taken),
    .branch_offset (bus.branch_offset),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .jr            (bus.jr),
    .jr_target     (bus.jr_target),
    .target        (target),
    .bad           (bad)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    fault_d = 1'b0;
    if (!bus.stall) begin
      unique case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (bad) begin
            pc_d    = EXC_VECTOR;
            epc_d   = pc_q;
            fault_d = 1'b1;
            state_d = TRAP;
          end else begin
            pc_d = target;
          end
        end
        TRAP: begin
          if (bus.eret) begin
            pc_d    = epc_q + 32'd4;
            state_d = RUN;
          end else if (bad) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d = target;
          end
        end
        HALT: state_d = HALT;
        default: state_d = HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      fault_q <= fault_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fetch_valid = fv;
  assign bus.fault       = fault_q;
  assign bus.epc         = epc_q;

`ifdef PC_RETIRE_CNT_EN
  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!bus.stall && fv) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bus.retired_count = cnt_q;
`else
  assign bus.retired_count = '0;
`endif

endmodule
